// File: rtl/fetch_if.sv
// fetch_if: fetch front-end bus bundle (imem request/response, instruction queue head, redirect)
// master: fetch_unit side; slave: memory / decode / branch-resolution side
interface fetch_if #(parameter int XLEN = 32);
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_resp_valid;
  logic [XLEN-1:0] imem_resp_data;
  logic            inst_valid;
  logic            inst_ready;
  logic [XLEN-1:0] inst_data;
  logic [XLEN-1:0] inst_pc;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  modport master (
    output imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc,
    input  imem_req_ready, imem_resp_valid, imem_resp_data, inst_ready, redirect_valid, redirect_pc
  );
  modport slave (
    input  imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc,
    output imem_req_ready, imem_resp_valid, imem_resp_data, inst_ready, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: sequential instruction prefetch with DEPTH-entry queue, credit-limited requests and redirect flush
// ports: clk, rst (async, active-high), bus (fetch_if.master);
// with FETCH_PERF_EN defined: perf_stall_cycles, perf_flushes (32-bit wrapping counters)
module fetch_unit #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic        clk,
  input  logic        rst,
  fetch_if.master     bus
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_stall_cycles,
  output logic [31:0] perf_flushes
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d, enq_pc_q, enq_pc_d;
  logic [CW-1:0]   count_q, count_d, outstanding_q, outstanding_d, discard_q, discard_d;
  logic [AW-1:0]   rd_q, rd_d, wr_q, wr_d;
  logic [XLEN-1:0] data_mem [DEPTH];
  logic [XLEN-1:0] pc_mem [DEPTH];
  logic            fire, push, pop, drop;
  logic [CW:0]     stale_sum, stale;
  logic [XLEN-1:0] redir_pc;
  assign redir_pc           = bus.redirect_pc & ~XLEN'(3);
  assign bus.imem_req_valid = !rst && !bus.redirect_valid &&
                              (({1'b0, count_q} + {1'b0, outstanding_q}) < (CW+1)'(DEPTH));
  assign bus.imem_req_addr  = fetch_pc_q;
  assign bus.inst_valid     = count_q != '0;
  assign bus.inst_data      = data_mem[rd_q];
  assign bus.inst_pc        = pc_mem[rd_q];
  always_comb begin
    fire      = bus.imem_req_valid && bus.imem_req_ready;
    drop      = bus.imem_resp_valid && discard_q != '0;
    push      = bus.imem_resp_valid && discard_q == '0 && outstanding_q != '0 && !bus.redirect_valid;
    pop       = bus.inst_valid && bus.inst_ready && !bus.redirect_valid;
    // a response arriving in the redirect cycle is itself stale, so it consumes one credit now
    stale_sum = {1'b0, discard_q} + {1'b0, outstanding_q};
    stale     = (stale_sum == '0) ? '0 : stale_sum - (CW+1)'(bus.imem_resp_valid);
    fetch_pc_d    = bus.redirect_valid ? redir_pc : fire ? fetch_pc_q + XLEN'(4) : fetch_pc_q;
    enq_pc_d      = bus.redirect_valid ? redir_pc : push ? enq_pc_q + XLEN'(4) : enq_pc_q;
    outstanding_d = bus.redirect_valid ? '0 : outstanding_q + CW'(fire) - CW'(push);
    discard_d     = bus.redirect_valid ? (stale[CW] ? '1 : stale[CW-1:0]) : discard_q - CW'(drop);
    count_d       = bus.redirect_valid ? '0 : count_q + CW'(push) - CW'(pop);
    wr_d          = bus.redirect_valid ? '0 : wr_q + AW'(push);
    rd_d          = bus.redirect_valid ? '0 : rd_q + AW'(pop);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      enq_pc_q      <= RESET_PC;
      count_q       <= '0;
      outstanding_q <= '0;
      discard_q     <= '0;
      rd_q          <= '0;
      wr_q          <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      enq_pc_q      <= enq_pc_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      rd_q          <= rd_d;
      wr_q          <= wr_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_q] <= bus.imem_resp_data;
      pc_mem[wr_q]   <= enq_pc_q;
    end
  end
`ifdef FETCH_PERF_EN
  logic [31:0] perf_stall_q, perf_stall_d, perf_flush_q, perf_flush_d;
  always_comb begin
    perf_stall_d = perf_stall_q + 32'(bus.inst_ready && !bus.inst_valid && !bus.redirect_valid);
    perf_flush_d = perf_flush_q + 32'(bus.redirect_valid);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_flush_q <= perf_flush_d;
    end
  end
  assign perf_stall_cycles = perf_stall_q;
  assign perf_flushes      = perf_flush_q;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench for fetch_unit with a fixed-latency in-order memory model
module tb_fetch_unit;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  fetch_if #(.XLEN(32)) bus();
`ifdef FETCH_PERF_EN
  logic [31:0] ps, pf;
`endif
  fetch_unit #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef FETCH_PERF_EN
    ,
    .perf_stall_cycles(ps),
    .perf_flushes(pf)
`endif
  );
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int lat = 1;
  int nreq = 0;
  logic [31:0] lastreq;
  logic [31:0] pa[$];
  int pd[$];
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got=%h want=%h", tag, got, exp);
    end
  endtask
  // one clock cycle: drive any due response, record an accepted request, end at the next negedge
  task automatic tick();
    if (pd.size() > 0 && pd[0] == cyc) begin
      bus.imem_resp_valid = 1'b1;
      bus.imem_resp_data  = pa[0] + 32'hA000_0000;
      void'(pa.pop_front());
      void'(pd.pop_front());
    end
    #1;
    if (bus.imem_req_valid && bus.imem_req_ready) begin
      pa.push_back(bus.imem_req_addr);
      pd.push_back(cyc + lat);
      lastreq = bus.imem_req_addr;
      nreq++;
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data  = '0;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    bus.imem_resp_valid = 1'b0;
    bus.redirect_valid  = 1'b0;
    pa.delete();
    pd.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    nreq = 0;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
  initial begin
    rst = 1'b1;
    bus.imem_req_ready  = 1'b1;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data  = '0;
    bus.inst_ready      = 1'b1;
    bus.redirect_valid  = 1'b0;
    bus.redirect_pc     = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req_valid", bus.imem_req_valid, 0);
    chk("rst_inst_valid", bus.inst_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    // streaming, latency 1
    #1;
    chk("t1_req_valid", bus.imem_req_valid, 1);
    chk("t1_addr0", bus.imem_req_addr, 32'h0);
    tick();
    chk("t1_addr1", bus.imem_req_addr, 32'h4);
    chk("t1_empty", bus.inst_valid, 0);
    tick();
    chk("t1_addr2", bus.imem_req_addr, 32'h8);
    chk("t1_valid0", bus.inst_valid, 1);
    chk("t1_pc0", bus.inst_pc, 32'h0);
    chk("t1_data0", bus.inst_data, 32'hA000_0000);
    tick();
    chk("t1_pc1", bus.inst_pc, 32'h4);
    chk("t1_data1", bus.inst_data, 32'hA000_0004);
    chk("t1_addr3", bus.imem_req_addr, 32'hC);
    tick();
    chk("t1_pc2", bus.inst_pc, 32'h8);
    chk("t1_data2", bus.inst_data, 32'hA000_0008);
    tick();
    chk("t1_pc3", bus.inst_pc, 32'hC);
    chk("t1_valid3", bus.inst_valid, 1);
    // backpressure fills the queue
    do_reset();
    lat = 1;
    bus.inst_ready = 1'b0;
    repeat (8) tick();
    chk("t2_nreq", nreq, 4);
    chk("t2_lastreq", lastreq, 32'hC);
    chk("t2_req_blocked", bus.imem_req_valid, 0);
    chk("t2_head_pc", bus.inst_pc, 32'h0);
    chk("t2_head_data", bus.inst_data, 32'hA000_0000);
    bus.inst_ready = 1'b1;
    #1;
    chk("t2_still_blocked", bus.imem_req_valid, 0);
    tick();
    chk("t2_resume_valid", bus.imem_req_valid, 1);
    chk("t2_resume_addr", bus.imem_req_addr, 32'h10);
    chk("t2_next_pc", bus.inst_pc, 32'h4);
    // redirect with 3 in flight, latency 3
    do_reset();
    lat = 3;
    bus.inst_ready = 1'b1;
    repeat (3) tick();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h100;
    #1;
    chk("t3_redir_noreq", bus.imem_req_valid, 0);
    tick();
    bus.redirect_valid = 1'b0;
    #1;
    chk("t3_req_valid", bus.imem_req_valid, 1);
    chk("t3_addr", bus.imem_req_addr, 32'h100);
    tick();
    chk("t3_drop_a", bus.inst_valid, 0);
    tick();
    chk("t3_drop_b", bus.inst_valid, 0);
    tick();
    chk("t3_drop_c", bus.inst_valid, 0);
    tick();
    chk("t3_valid", bus.inst_valid, 1);
    chk("t3_pc", bus.inst_pc, 32'h100);
    chk("t3_data", bus.inst_data, 32'hA000_0100);
    // unaligned redirect concurrent with a response, outstanding 2, queue non-empty
    do_reset();
    lat = 2;
    bus.inst_ready = 1'b0;
    repeat (3) tick();
    chk("t4_pre_valid", bus.inst_valid, 1);
    chk("t4_pre_pc", bus.inst_pc, 32'h0);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h203;
    tick();
    bus.redirect_valid = 1'b0;
    #1;
    chk("t4_flushed", bus.inst_valid, 0);
    chk("t4_req_valid", bus.imem_req_valid, 1);
    chk("t4_addr", bus.imem_req_addr, 32'h200);
    tick();
    chk("t4_dropped", bus.inst_valid, 0);
    repeat (2) tick();
    chk("t4_valid", bus.inst_valid, 1);
    chk("t4_pc", bus.inst_pc, 32'h200);
    chk("t4_data", bus.inst_data, 32'hA000_0200);
    // address wrap
    do_reset();
    lat = 1;
    bus.inst_ready     = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'hFFFF_FFFC;
    tick();
    bus.redirect_valid = 1'b0;
    #1;
    chk("t5_addr_top", bus.imem_req_addr, 32'hFFFF_FFFC);
    tick();
    chk("t5_addr_wrap", bus.imem_req_addr, 32'h0);
    tick();
    chk("t5_pc_top", bus.inst_pc, 32'hFFFF_FFFC);
    chk("t5_data_top", bus.inst_data, 32'h9FFF_FFFC);
    tick();
    chk("t5_pc_wrap", bus.inst_pc, 32'h0);
    chk("t5_data_wrap", bus.inst_data, 32'hA000_0000);
    // async reset with a full queue
    bus.inst_ready = 1'b0;
    repeat (10) tick();
    chk("t6_full_valid", bus.inst_valid, 1);
    chk("t6_full_noreq", bus.imem_req_valid, 0);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_async_inst", bus.inst_valid, 0);
    chk("t6_async_req", bus.imem_req_valid, 0);
    pa.delete();
    pd.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    nreq = 0;
    #1;
    chk("t6_restart_valid", bus.imem_req_valid, 1);
    chk("t6_restart_addr", bus.imem_req_addr, 32'h0);
    // back-to-back redirects, each with a concurrent response
    lat = 2;
    bus.inst_ready = 1'b1;
    repeat (2) tick();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h300;
    tick();
    bus.redirect_pc    = 32'h400;
    tick();
    bus.redirect_valid = 1'b0;
    #1;
    chk("t7_addr", bus.imem_req_addr, 32'h400);
`ifdef FETCH_PERF_EN
    chk("t7_perf_flushes", pf, 32'd2);
`endif
    repeat (3) tick();
    chk("t7_valid", bus.inst_valid, 1);
    chk("t7_pc", bus.inst_pc, 32'h400);
    chk("t7_data", bus.inst_data, 32'hA000_0400);
`ifdef FETCH_PERF_EN
    chk("t7_perf_stall", ps, 32'd5);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Parametrised instruction-fetch front end for the RV32 core. It decouples PC generation from the decode/execute stage. It issues sequential fetch requests to a variable-latency instruction memory through a valid/ready handshake and buffers returned words with their PCs in a DEPTH-entry prefetch queue. On a redirect from branch/jump resolution it flushes the queue and discards stale in-flight responses.

Parameters:
XLEN, 32, data/address width in bits.
DEPTH, 4, prefetch queue entries; power of 2, minimum 2; also the maximum outstanding requests.
RESET_PC, 32'h0000_0000, fetch address after reset; bits [1:0] must be 0.

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous reset, active-high
imem_req_valid  output  1  fetch request valid
imem_req_ready  input  1  memory accepts request
imem_req_addr  output  XLEN  fetch address, word aligned
imem_resp_valid  input  1  response word valid; responses return in request order
imem_resp_data  input  XLEN  instruction word
inst_valid  output  1  queue head valid
inst_ready  input  1  consumer takes head
inst_data  output  XLEN  head instruction
inst_pc  output  XLEN  head PC
redirect_valid  input  1  flush and refetch
redirect_pc  input  XLEN  new fetch PC; bits [1:0] ignored (forced 0)

Behaviour:
- Reset (async, any cycle, including with requests in flight):
  - fetch_pc = RESET_PC.
  - Queue empty; outstanding = 0; discard = 0.
  - inst_valid = 0; imem_req_valid = 0 while rst is high.
- Counters: count (queue occupancy), outstanding (accepted requests without a response, not yet marked stale), discard (stale responses still to drop). Each counter is clog2(DEPTH)+1 bits.
- Request:
  - imem_req_valid = !redirect_valid && (count + outstanding < DEPTH).
  - imem_req_addr = fetch_pc.
  - On req_valid && req_ready: outstanding += 1 and fetch_pc += 4. fetch_pc wraps modulo 2^XLEN.
- Response:
  - If discard > 0: drop the response, discard -= 1.
  - Else if outstanding > 0: push {fetch address, data}, outstanding -= 1. Space is guaranteed by the credit rule.
  - Else: protocol violation; drop the response, state unchanged.
- Each queue entry's PC is the address of the request it answers. Keep an internal request-address tracker, or an enqueue PC register that advances by 4 per push and reloads on redirect.
- Dequeue:
  - inst_valid = (count != 0); inst_data and inst_pc are driven from the head entry.
  - Pop on inst_valid && inst_ready.
  - Push and pop in the same cycle leave count unchanged, and are legal when full or empty with one entry.
  - Minimum latency: a response in cycle N appears on inst_valid in cycle N+1.
- Redirect cycle (highest priority):
  - No request is issued; any pop is ignored; the queue is flushed (count = 0).
  - fetch_pc = {redirect_pc[XLEN-1:2], 2'b00}.
  - discard_next = discard + outstanding - imem_resp_valid (saturate at 0); outstanding = 0.
  - The first post-redirect request issues the next cycle.
  - Back-to-back redirects: the last one wins, and the stale count accumulates.
- Head outputs are stable while inst_valid && !inst_ready, unless a redirect occurs.

Optional Feature:
- Macro FETCH_PERF_EN.
- When defined:
  - Add outputs perf_stall_cycles (32 bits) and perf_flushes (32 bits), both reset to 0.
  - perf_stall_cycles increments each cycle inst_ready = 1 && inst_valid = 0 && no redirect.
  - perf_flushes increments per redirect cycle.
  - Both counters wrap at 2^32.
- When not defined: the ports and logic are absent, and behaviour is otherwise identical.

Test Plan:
- Reset, then memory with 1-cycle latency, req_ready = 1, inst_ready = 1 -> addresses 0x0, 0x4, 0x8 requested on consecutive cycles; inst_pc sequence is 0x0, 0x4, 0x8 with matching data; steady state gives 1 instruction per cycle.
- inst_ready = 0 with DEPTH = 4 -> exactly 4 requests (0x0 to 0xC) issued, then imem_req_valid stays 0. Raising inst_ready resumes fetch at 0x10 after the first pop.
- Memory latency 3 cycles, 3 requests in flight, redirect_pc = 0x100 -> queue flushed; the 3 stale responses are dropped; next request address is 0x100; first inst_pc out is 0x100.
- redirect_pc = 0x203 -> imem_req_addr = 0x200. Redirect in the same cycle as a response with outstanding = 2 -> discard = 1, the next response is dropped.
- fetch_pc = 0xFFFF_FFFC -> the following request address is 0x0000_0000.
- Assert rst mid-stream with a full queue -> inst_valid and imem_req_valid drop immediately (async). After release, fetch restarts at RESET_PC. With FETCH_PERF_EN, two redirects give perf_flushes = 2.
